// File: rtl/led_pattern_pkg.sv
// -----------------------------------------------------------------------------
// led_pattern_pkg
// Shared types and constants for the LED pattern generator.
//   mode_e   : pattern mode (COUNT, SCAN, BLINK, HOLD), 2 bits
//   state_e  : mode-change FSM state (RUN, SWITCH)
//   SEED_*   : pattern loaded when a mode change takes effect
//   scan_step: next one-hot bounce value and direction
// -----------------------------------------------------------------------------
package led_pattern_pkg;

    typedef enum logic [1:0] {
        MODE_COUNT = 2'd0,
        MODE_SCAN  = 2'd1,
        MODE_BLINK = 2'd2,
        MODE_HOLD  = 2'd3
    } mode_e;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_SWITCH = 1'b1
    } state_e;

    localparam logic [3:0] SEED_COUNT  = 4'b0000;
    localparam logic [3:0] SEED_SCAN   = 4'b0001;
    localparam logic [3:0] SEED_BLINK  = 4'b0000;
    localparam logic [3:0] SCAN_TOP    = 4'b1000;
    localparam logic [3:0] SCAN_BOTTOM = 4'b0001;

    // Returns {dir_up_next, pattern_next}. Direction flips on arriving at
    // either end so the end value is shown exactly once per bounce. A
    // non-one-hot value (not reachable after a reseed) recovers to the seed.
    function automatic logic [4:0] scan_step(input logic [3:0] pat,
                                             input logic       dir_up);
        logic [3:0] nxt;
        logic       ndir;
        nxt  = dir_up ? {pat[2:0], 1'b0} : {1'b0, pat[3:1]};
        ndir = dir_up;
        if (nxt == SCAN_TOP) begin
            ndir = 1'b0;
        end else if (nxt == SCAN_BOTTOM) begin
            ndir = 1'b1;
        end else if (nxt == 4'b0000) begin
            nxt  = SEED_SCAN;
            ndir = 1'b1;
        end else begin
            ndir = dir_up;
        end
        return {ndir, nxt};
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// -----------------------------------------------------------------------------
// tick_prescaler
// Free-running LOG2DELAY-bit up counter; tick is high while the count is
// all-ones, i.e. one cycle in every 2^LOG2DELAY. The count wraps to zero.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   tick  : combinational all-ones detect (registered by the consumer)
// -----------------------------------------------------------------------------
module tick_prescaler #(
    parameter int LOG2DELAY = 25
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    if ((LOG2DELAY < 2) || (LOG2DELAY > 31)) begin : g_log2delay_check
        $error("tick_prescaler: LOG2DELAY must be in 2..31");
    end

    logic [LOG2DELAY-1:0] r_cnt;

    // Prescaler counter, natural wrap from all-ones to zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= {LOG2DELAY{1'b0}};
        end else begin
            r_cnt <= r_cnt + {{(LOG2DELAY-1){1'b0}}, 1'b1};
        end
    end

    assign tick = (r_cnt == {LOG2DELAY{1'b1}});

endmodule

// File: rtl/led_pattern_gen.sv
// -----------------------------------------------------------------------------
// led_pattern_gen
// Free-running LED pattern generator with four modes and a valid/ready
// mode-change handshake; a new mode takes effect on the next prescaler tick.
//   clk          : clock, rising edge
//   rst_n        : asynchronous active-low reset
//   mode_i       : requested mode (0 COUNT, 1 SCAN, 2 BLINK, 3 HOLD)
//   mode_valid_i : request valid
//   mode_ready_o : request can be accepted (registered)
//   dim_i        : brightness 0..15 (only with LED_PATTERN_DIM_EN)
//   led_o        : pattern to LED OBUFs (PWM-gated with LED_PATTERN_DIM_EN)
//   diff_o       : ungated pattern bit 0, to OBUFTDS I input
//   tick_o       : one-cycle pulse aligned with each new pattern
// Build option: define LED_PATTERN_DIM_EN to add dim_i and the PWM gate
// (led_o then has one extra register stage).
// -----------------------------------------------------------------------------
module led_pattern_gen
    import led_pattern_pkg::*;
#(
    parameter int LOG2DELAY = 25,
    parameter int NLEDS     = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       mode_i,
    input  logic             mode_valid_i,
`ifdef LED_PATTERN_DIM_EN
    input  logic [3:0]       dim_i,
`endif
    output logic             mode_ready_o,
    output logic [NLEDS-1:0] led_o,
    output logic             diff_o,
    output logic             tick_o
);

    if (NLEDS != 4) begin : g_nleds_check
        $error("led_pattern_gen: NLEDS must be 4 in this revision");
    end

    logic             w_tick;
    state_e           r_state;
    mode_e            r_mode;
    mode_e            r_pend_mode;
    logic             r_dir_up;
    logic [NLEDS-1:0] r_pattern;
    logic             r_ready;
    logic             r_tick;
    logic [NLEDS-1:0] w_step_pat;
    logic             w_step_dir;
    logic [NLEDS-1:0] w_seed_pat;
    logic [4:0]       w_scan;

    tick_prescaler #(
        .LOG2DELAY (LOG2DELAY)
    ) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (w_tick)
    );

    // Next pattern when stepping in the current mode.
    always_comb begin
        w_step_pat = r_pattern;
        w_step_dir = r_dir_up;
        w_scan     = scan_step(r_pattern, r_dir_up);
        case (r_mode)
            MODE_COUNT: w_step_pat = r_pattern + 4'd1;
            MODE_SCAN: begin
                w_step_pat = w_scan[3:0];
                w_step_dir = w_scan[4];
            end
            MODE_BLINK: w_step_pat = ~r_pattern;
            MODE_HOLD:  w_step_pat = r_pattern;
            default:    w_step_pat = r_pattern;
        endcase
    end

    // Seed pattern loaded when the pending mode takes effect.
    always_comb begin
        w_seed_pat = r_pattern;
        case (r_pend_mode)
            MODE_COUNT: w_seed_pat = SEED_COUNT;
            MODE_SCAN:  w_seed_pat = SEED_SCAN;
            MODE_BLINK: w_seed_pat = SEED_BLINK;
            MODE_HOLD:  w_seed_pat = r_pattern;
            default:    w_seed_pat = r_pattern;
        endcase
    end

    // Mode-change FSM, pattern register, handshake and tick pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_RUN;
            r_mode      <= MODE_COUNT;
            r_pend_mode <= MODE_COUNT;
            r_dir_up    <= 1'b1;
            r_pattern   <= {NLEDS{1'b0}};
            r_ready     <= 1'b1;
            r_tick      <= 1'b0;
        end else begin
            r_tick <= w_tick;
            case (r_state)
                ST_RUN: begin
                    // A tick in the accept cycle still steps the old mode;
                    // the reseed waits for the following tick.
                    if (w_tick) begin
                        r_pattern <= w_step_pat;
                        r_dir_up  <= w_step_dir;
                    end
                    if (mode_valid_i && r_ready) begin
                        r_pend_mode <= mode_e'(mode_i);
                        r_state     <= ST_SWITCH;
                        r_ready     <= 1'b0;
                    end
                end
                ST_SWITCH: begin
                    if (w_tick) begin
                        r_mode    <= r_pend_mode;
                        r_pattern <= w_seed_pat;
                        if (r_pend_mode == MODE_SCAN) begin
                            r_dir_up <= 1'b1;
                        end
                        r_state <= ST_RUN;
                        r_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_RUN;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

    assign mode_ready_o = r_ready;
    assign tick_o       = r_tick;
    assign diff_o       = r_pattern[0];

`ifdef LED_PATTERN_DIM_EN
    logic [3:0]       r_pwm;
    logic [NLEDS-1:0] r_led;
    logic             w_pwm_on;

    // 5-bit compare so dim_i=15 (threshold 16) keeps the LEDs always on.
    assign w_pwm_on = ({1'b0, r_pwm} < ({1'b0, dim_i} + 5'd1));

    // Free-running PWM phase counter and gated LED output stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pwm <= 4'd0;
            r_led <= {NLEDS{1'b0}};
        end else begin
            r_pwm <= r_pwm + 4'd1;
            r_led <= r_pattern & {NLEDS{w_pwm_on}};
        end
    end

    assign led_o = r_led;
`else
    assign led_o = r_pattern;
`endif

endmodule

// File: tb/tb_led_pattern_gen.sv
// -----------------------------------------------------------------------------
// tb_led_pattern_gen
// Directed self-checking bench for led_pattern_gen with LOG2DELAY=3.
// Inputs are driven and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_led_pattern_gen;

    logic       clk;
    logic       rst_n;
    logic [1:0] mode_i;
    logic       mode_valid_i;
    logic [3:0] dim_i;
    logic       mode_ready_o;
    logic [3:0] led_o;
    logic       diff_o;
    logic       tick_o;

    int n_total = 0;
    int n_pass  = 0;

    led_pattern_gen #(
        .LOG2DELAY (3),
        .NLEDS     (4)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .mode_i       (mode_i),
        .mode_valid_i (mode_valid_i),
`ifdef LED_PATTERN_DIM_EN
        .dim_i        (dim_i),
`endif
        .mode_ready_o (mode_ready_o),
        .led_o        (led_o),
        .diff_o       (diff_o),
        .tick_o       (tick_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Waits (bounded) for the next tick_o; reports cycles waited and how many
    // sampled cycles before the tick had mode_ready_o high.
    task automatic wait_tick(output int n, output int rdy_hi);
        bit to;
        n = 0; rdy_hi = 0; to = 1'b1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            n++;
            if (tick_o) begin
                to = 1'b0;
                break;
            end
            if (mode_ready_o) rdy_hi++;
        end
        n_total++;
        if (to) $display("FAIL tick_timeout: no tick_o within %0d cycles, required one", n);
        else n_pass++;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_total++; if (led_o !== 4'b0000) $display("FAIL rst_led: got %b want 0000", led_o); else n_pass++;
        n_total++; if (diff_o !== 1'b0) $display("FAIL rst_diff: got %b want 0", diff_o); else n_pass++;
        n_total++; if (tick_o !== 1'b0) $display("FAIL rst_tick: got %b want 0", tick_o); else n_pass++;
        n_total++; if (mode_ready_o !== 1'b1) $display("FAIL rst_ready: got %b want 1", mode_ready_o); else n_pass++;
        rst_n = 1'b1;
    endtask

    task automatic test_count();
        int n, r;
        logic [3:0] exp;
        for (int i = 1; i <= 17; i++) begin
            wait_tick(n, r);
            exp = i[3:0];
            n_total++; if (led_o !== exp) $display("FAIL count_led[%0d]: got %b want %b", i, led_o, exp); else n_pass++;
            n_total++; if (diff_o !== exp[0]) $display("FAIL count_diff[%0d]: got %b want %b", i, diff_o, exp[0]); else n_pass++;
            n_total++; if (n != 8) $display("FAIL count_period[%0d]: got %0d want 8", i, n); else n_pass++;
        end
    endtask

    task automatic test_scan();
        int n, r;
        logic [3:0] exp_seq [8] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000,
                                    4'b0100, 4'b0010, 4'b0001, 4'b0010};
        repeat (3) @(negedge clk);
        mode_valid_i = 1'b1; mode_i = 2'd1;
        @(negedge clk);
        mode_valid_i = 1'b0;
        n_total++; if (mode_ready_o !== 1'b0) $display("FAIL scan_ready_low: got %b want 0", mode_ready_o); else n_pass++;
        for (int k = 0; k < 8; k++) begin
            wait_tick(n, r);
            if (k == 0) begin
                n_total++; if (r != 0) $display("FAIL scan_ready_switch: ready high %0d cycles want 0", r); else n_pass++;
                n_total++; if (mode_ready_o !== 1'b1) $display("FAIL scan_ready_rise: got %b want 1", mode_ready_o); else n_pass++;
            end
            n_total++; if (led_o !== exp_seq[k]) $display("FAIL scan_led[%0d]: got %b want %b", k, led_o, exp_seq[k]); else n_pass++;
        end
    endtask

    task automatic test_coincident();
        int n, r;
        repeat (3) @(negedge clk);
        mode_valid_i = 1'b1; mode_i = 2'd0;
        @(negedge clk);
        mode_valid_i = 1'b0;
        for (int k = 0; k < 6; k++) wait_tick(n, r);
        n_total++; if (led_o !== 4'b0101) $display("FAIL coin_setup: got %b want 0101", led_o); else n_pass++;
        // Seven cycles after tick_o is the internal-tick cycle.
        repeat (7) @(negedge clk);
        mode_valid_i = 1'b1; mode_i = 2'd2;
        @(negedge clk);
        mode_valid_i = 1'b0;
        n_total++; if (tick_o !== 1'b1) $display("FAIL coin_tick: got %b want 1", tick_o); else n_pass++;
        n_total++; if (led_o !== 4'b0110) $display("FAIL coin_old_step: got %b want 0110", led_o); else n_pass++;
        n_total++; if (mode_ready_o !== 1'b0) $display("FAIL coin_ready: got %b want 0", mode_ready_o); else n_pass++;
        wait_tick(n, r);
        n_total++; if (led_o !== 4'b0000) $display("FAIL coin_seed: got %b want 0000", led_o); else n_pass++;
        n_total++; if (n != 8) $display("FAIL coin_period: got %0d want 8", n); else n_pass++;
        wait_tick(n, r);
        n_total++; if (led_o !== 4'b1111) $display("FAIL coin_blink: got %b want 1111", led_o); else n_pass++;
    endtask

    task automatic test_back_to_back();
        int n, r;
        mode_valid_i = 1'b1; mode_i = 2'd1;
        wait_tick(n, r);
        n_total++; if (r != 0) $display("FAIL b2b_ready1: ready high %0d cycles want 0", r); else n_pass++;
        n_total++; if (led_o !== 4'b0001) $display("FAIL b2b_scan_seed: got %b want 0001", led_o); else n_pass++;
        n_total++; if (mode_ready_o !== 1'b1) $display("FAIL b2b_rise1: got %b want 1", mode_ready_o); else n_pass++;
        mode_i = 2'd0;
        wait_tick(n, r);
        n_total++; if (r != 0) $display("FAIL b2b_ready2: ready high %0d cycles want 0", r); else n_pass++;
        n_total++; if (led_o !== 4'b0000) $display("FAIL b2b_count_seed: got %b want 0000", led_o); else n_pass++;
        n_total++; if (mode_ready_o !== 1'b1) $display("FAIL b2b_rise2: got %b want 1", mode_ready_o); else n_pass++;
    endtask

    task automatic test_reset_mid_switch();
        int n, r;
        mode_i = 2'd2;
        @(negedge clk);
        mode_valid_i = 1'b0;
        n_total++; if (mode_ready_o !== 1'b0) $display("FAIL rsw_accept: got %b want 0", mode_ready_o); else n_pass++;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_total++; if (mode_ready_o !== 1'b1) $display("FAIL rsw_ready: got %b want 1", mode_ready_o); else n_pass++;
        n_total++; if (led_o !== 4'b0000) $display("FAIL rsw_led: got %b want 0000", led_o); else n_pass++;
        n_total++; if (diff_o !== 1'b0) $display("FAIL rsw_diff: got %b want 0", diff_o); else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        wait_tick(n, r);
        n_total++; if (n != 8) $display("FAIL rsw_period: got %0d want 8", n); else n_pass++;
        n_total++; if (led_o !== 4'b0001) $display("FAIL rsw_count1: got %b want 0001", led_o); else n_pass++;
        wait_tick(n, r);
        n_total++; if (led_o !== 4'b0010) $display("FAIL rsw_count2: got %b want 0010", led_o); else n_pass++;
    endtask

`ifdef LED_PATTERN_DIM_EN
    task automatic test_dim();
        int n, r;
        int on_cnt [4];
        int diff_hi;
        repeat (3) @(negedge clk);
        mode_valid_i = 1'b1; mode_i = 2'd2;
        @(negedge clk);
        mode_valid_i = 1'b0;
        wait_tick(n, r);
        wait_tick(n, r);
        n_total++; if (diff_o !== 1'b1) $display("FAIL dim_blink: got %b want 1", diff_o); else n_pass++;
        repeat (2) @(negedge clk);
        mode_valid_i = 1'b1; mode_i = 2'd3;
        @(negedge clk);
        mode_valid_i = 1'b0;
        wait_tick(n, r);
        for (int lvl = 0; lvl < 2; lvl++) begin
            dim_i = (lvl == 0) ? 4'd3 : 4'd15;
            repeat (2) @(negedge clk);
            diff_hi = 0;
            for (int b = 0; b < 4; b++) on_cnt[b] = 0;
            for (int c = 0; c < 16; c++) begin
                @(negedge clk);
                if (diff_o) diff_hi++;
                for (int b = 0; b < 4; b++) if (led_o[b]) on_cnt[b]++;
            end
            for (int b = 0; b < 4; b++) begin
                n_total++;
                if (on_cnt[b] != ((lvl == 0) ? 4 : 16))
                    $display("FAIL dim_duty[%0d][%0d]: got %0d want %0d", dim_i, b, on_cnt[b], (lvl == 0) ? 4 : 16);
                else n_pass++;
            end
            n_total++; if (diff_hi != 16) $display("FAIL dim_diff[%0d]: got %0d want 16", dim_i, diff_hi); else n_pass++;
        end
    endtask
`endif

    initial begin
        rst_n        = 1'b0;
        mode_i       = 2'd0;
        mode_valid_i = 1'b0;
        dim_i        = 4'd15;
        test_reset();
`ifdef LED_PATTERN_DIM_EN
        test_dim();
`else
        test_count();
        test_scan();
        test_coincident();
        test_back_to_back();
        test_reset_mid_switch();
`endif
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/led_pattern_gen.md
# led_pattern_gen

Free-running LED/indicator pattern generator for the board bring-up designs. It feeds the output-buffer stage: `led_o` drives the single-ended LED OBUFs, and `diff_o` drives the I input of the differential OBUFTDS. It contains a programmable prescaler, a four-mode pattern state machine, and a valid/ready mode-change handshake. The mode change is applied on the next prescaler tick, so the visible pattern never glitches mid-period.

## Interface
- `LOG2DELAY`, default 25: a tick occurs every 2^LOG2DELAY clock cycles. Legal range is 2..31.
- `NLEDS`, default 4: width of the pattern. It is fixed at 4 in this revision; an elaboration error fires on any other value.
- `clk`  input  1  sole clock, rising edge.
- `rst_n`  input  1  reset, asynchronous assert, active-low.
- `mode_i`  input  2  requested mode: 0=COUNT, 1=SCAN, 2=BLINK, 3=HOLD.
- `mode_valid_i`  input  1  mode request valid.
- `mode_ready_o`  output  1  request can be accepted.
- `led_o`  output  NLEDS  pattern to the LED OBUFs.
- `diff_o`  output  1  equals the ungated pattern bit 0; goes to the OBUFTDS I input.
- `tick_o`  output  1  registered one-cycle pulse on each prescaler tick.
- `dim_i`  input  4  brightness level. Present only with `LED_PATTERN_DIM_EN`.

## Operation
- Reset values: prescaler 0, pattern 0000, mode COUNT, scan direction up, state RUN, `mode_ready_o`=1, `tick_o`=0, `diff_o`=0, `led_o`=0000.
- Prescaler: LOG2DELAY-bit up counter.
  - An internal tick is raised when the count equals all-ones.
  - The count then wraps to 0.
  - The counter is never cleared by a mode change.
- Pattern step on each tick while in RUN:
  - COUNT: binary increment, mod 16 (1111→0000).
  - SCAN: one-hot bounce 0001→0010→0100→1000→0100→0010→0001→0010…
    - The direction flips on reaching 1000 and on reaching 0001.
  - BLINK: bitwise invert (0000↔1111).
  - HOLD: no change.
- FSM states are RUN and SWITCH.
- RUN:
  - `mode_ready_o`=1.
  - On `mode_valid_i & mode_ready_o`, `mode_i` is latched into `pend_mode` and the FSM goes to SWITCH.
- SWITCH:
  - `mode_ready_o`=0. Requests are ignored.
  - On the next tick, mode becomes `pend_mode` and the pattern is loaded with the new mode's seed instead of being stepped.
    - Seeds: COUNT 0000, SCAN 0001 with direction up, BLINK 0000, HOLD keeps the current pattern.
  - The FSM then returns to RUN.
- Accept coincident with a tick:
  - That tick steps the pattern using the old mode.
  - The seed is loaded at the following tick, 2^LOG2DELAY cycles later.
- Request for the mode already active: a full SWITCH is still performed, so the pattern reseeds.
- `rst_n` asserted mid-SWITCH: the pending request is discarded and all reset values apply immediately.

## Timing
- `led_o`/`diff_o` update on the clock edge that ends the tick cycle. Latency from internal tick to output is 1 cycle.
- `tick_o` is high in the cycle after the internal tick, aligned with the new pattern.
- `mode_ready_o` falls in the cycle after the accept. It rises in the cycle after the reseed edge.
- All outputs are registered; there are no combinational input→output paths.

## Configuration
- `LED_PATTERN_DIM_EN` defined:
  - Adds the `dim_i` port and a free-running 4-bit PWM counter (reset 0, wraps 15→0).
  - `led_o[k]` = `pattern[k] & (pwm < dim_i+1)`, with a 5-bit compare.
    - Duty cycle is (dim_i+1)/16: dim_i=15 is always on, dim_i=0 is 1/16.
  - `led_o` gains one extra register stage, so latency is 2 cycles.
  - `diff_o` and `tick_o` are unaffected and keep 1-cycle latency.
- Undefined: no `dim_i` port, no PWM logic; `led_o` is the pattern register.

## Structure
- `led_pattern_pkg` holds:
  - `mode_e` (COUNT, SCAN, BLINK, HOLD; 2 bits)
  - `state_e` (RUN, SWITCH)
  - seed constants per mode.
- Sub-module `tick_prescaler`:
  - Parameter LOG2DELAY.
  - Ports: `clk`, `rst_n`, `tick`.
  - Contains the counter and the all-ones detect.
- The top module holds the FSM, pattern register, handshake, and optional PWM gate.

## Test plan
- Use LOG2DELAY=3 (tick every 8 cycles) throughout.
- Reset, then run COUNT for 17 ticks:
  - All outputs at reset values during reset.
  - `led_o` = 0001, 0010, … 1111, 0000, 0001.
  - `tick_o` pulses exactly every 8 cycles.
- Request SCAN mid-period:
  - `mode_ready_o` is 0 from the cycle after the accept until the cycle after the next tick.
  - Pattern sequence 0001, 0010, 0100, 1000, 0100, 0010, 0001, 0010.
- Assert `mode_valid_i` in the internal-tick cycle, with COUNT at 0101 and mode_i=BLINK:
  - Next output is 0110.
  - The following tick gives 0000, then 1111.
- Hold `mode_valid_i` high continuously with alternating modes: only one accept per SWITCH; later requests wait for ready.
- Drop `rst_n` for 1 cycle during SWITCH:
  - Outputs go to 0000 and ready goes to 1 asynchronously.
  - The pending BLINK is never applied and COUNT resumes.
- With `LED_PATTERN_DIM_EN`, BLINK at 1111 and dim_i=3:
  - Each `led_o` bit is high exactly 4 of every 16 cycles.
  - dim_i=15 gives always on.
  - `diff_o` is not gated.
